// File: rtl/entry_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : entry_seq_pkg
// Brief    : Shared types and widths for the calculator entry sequencer.
// Revision : 1.0
// ============================================================================
package entry_seq_pkg;

    localparam int PHASE_W = 3;
    localparam int OPC_W   = 3;
    localparam int DATA_W  = 8;
    localparam int RES_W   = 16;

    // Encodings double as the phase code shown on the display.
    typedef enum logic [PHASE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_GET_A  = 3'd1,
        ST_GET_B  = 3'd2,
        ST_GET_OP = 3'd3,
        ST_ISSUE  = 3'd4,
        ST_WAIT   = 3'd5,
        ST_SHOW   = 3'd6
    } state_e;

    function automatic logic is_entry(input state_e s);
        return (s == ST_GET_A) || (s == ST_GET_B) || (s == ST_GET_OP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/entry_sequencer_rise.sv
`default_nettype none
// ============================================================================
// Module   : rise_detect
// Brief    : Single-flop rising-edge detector for a raw button level.
// Revision : 1.0
// ============================================================================
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_in;
        end
    end

    assign rise = sig_in & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/entry_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : entry_sequencer
// Brief    : Sequences operand/opcode entry, one ALU operation and result hold.
// Revision : 1.0
// ============================================================================
module entry_sequencer
    import entry_seq_pkg::*;
#(
    parameter int NUM_OPS      = 6,
    parameter int WAIT_TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_start,
    input  logic               btn_clear,
    input  logic [DATA_W-1:0]  iu_value,
    input  logic               iu_value_ready,
    output logic               iu_enable,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [OPC_W-1:0]   alu_op,
    output logic               alu_start,
    input  logic               alu_done,
    input  logic [RES_W-1:0]   alu_result,
    output logic [RES_W-1:0]   result,
    output logic               result_valid,
    output logic               err,
    output logic [PHASE_W-1:0] phase
);

    localparam int                 CNT_W     = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(WAIT_TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(WAIT_TIMEOUT - 1);
    localparam logic [DATA_W-1:0]  NUM_OPS_V = DATA_W'(NUM_OPS);

    logic start_rise, clear_rise;

    rise_detect u_start_rise (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (btn_start),
        .rise   (start_rise)
    );

    rise_detect u_clear_rise (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (btn_clear),
        .rise   (clear_rise)
    );

    state_e              state_q,        state_d;
    logic                iu_enable_q,    iu_enable_d;
    logic [DATA_W-1:0]   alu_a_q,        alu_a_d;
    logic [DATA_W-1:0]   alu_b_q,        alu_b_d;
    logic [OPC_W-1:0]    alu_op_q,       alu_op_d;
    logic                alu_start_q,    alu_start_d;
    logic [RES_W-1:0]    result_q,       result_d;
    logic                result_valid_q, result_valid_d;
    logic                err_q,          err_d;
    logic [CNT_W-1:0]    cnt_q,          cnt_d;
    logic                capture;

    always_comb begin
        state_d        = state_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_op_d       = alu_op_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        err_d          = err_q;
        cnt_d          = cnt_q;
        capture        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) state_d = ST_GET_A;
            end
            ST_GET_A: begin
                if (iu_value_ready) begin
                    alu_a_d = iu_value;
                    capture = 1'b1;
                    state_d = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (iu_value_ready) begin
                    alu_b_d = iu_value;
                    capture = 1'b1;
                    state_d = ST_GET_OP;
                end
            end
            ST_GET_OP: begin
                if (iu_value_ready) begin
                    capture = 1'b1;
                    if (iu_value < NUM_OPS_V) begin
                        alu_op_d = iu_value[OPC_W-1:0];
                        err_d    = 1'b0;
                        state_d  = ST_ISSUE;
                    end else begin
                        err_d    = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                // A completion in the timeout cycle still counts as a good result.
                if (alu_done) begin
                    result_d       = alu_result;
                    result_valid_d = 1'b1;
                    state_d        = ST_SHOW;
                end else if (cnt_q >= CNT_LAST) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (start_rise) begin
                    result_valid_d = 1'b0;
                    err_d          = 1'b0;
                    alu_a_d        = '0;
                    alu_b_d        = '0;
                    state_d        = ST_GET_A;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear_rise) begin
            state_d        = ST_IDLE;
            alu_a_d        = '0;
            alu_b_d        = '0;
            alu_op_d       = '0;
            result_d       = '0;
            result_valid_d = 1'b0;
            err_d          = 1'b0;
            cnt_d          = '0;
            capture        = 1'b0;
        end

        // The entry unit is held low for one cycle after each capture to flush it.
        alu_start_d = (state_d == ST_ISSUE);
        iu_enable_d = is_entry(state_d) && !capture;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            iu_enable_q    <= 1'b0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_op_q       <= '0;
            alu_start_q    <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            iu_enable_q    <= iu_enable_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_op_q       <= alu_op_d;
            alu_start_q    <= alu_start_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            err_q          <= err_d;
            cnt_q          <= cnt_d;
        end
    end

    assign iu_enable    = iu_enable_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign alu_start    = alu_start_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign err          = err_q;
    assign phase        = state_q;

endmodule
`default_nettype wire
